eth_tx_fcs_insert: RTL and testbench

Transmit-path frame finisher in the 10G MAC, between the TX client interface and the XGMII encoder. It accepts a 32-bit byte-lane stream of frame bytes (preamble/SFD already stripped), optionally zero-pads short frames to the minimum length, and computes the Ethernet CRC-32. It then appends the 4-byte FCS directly after the last byte. The CRC logic is the codebase `crc32` engine: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, output inverted. It is either instantiated with SLICE_LENGTH=4 or computed equivalently in-block.

---
 rtl/eth_tx_fcs_insert.sv | 249 ++++++++++++++++++++++++
 tb/tb_eth_tx_fcs_insert.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_fcs_insert.sv
// Transmit frame finisher: optional zero padding to a minimum length, then
// the Ethernet CRC-32 appended as a 4-byte FCS right after the last byte.
module eth_tx_fcs_insert #(
  parameter int ENABLE_PAD    = 1,
  parameter int MIN_FRAME_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic [3:0]  s_keep,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready
);

  localparam logic [1:0]  ST_DATA     = 2'd0;
  localparam logic [1:0]  ST_PAD      = 2'd1;
  localparam logic [1:0]  ST_FCS_FULL = 2'd2;
  localparam logic [1:0]  ST_FCS_TAIL = 2'd3;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME_LEN);
  localparam logic        PAD_EN   = (ENABLE_PAD != 0);

  // Reflected CRC-32 over the lowest n_bytes lanes, lane 0 first.
  function automatic logic [31:0] crc_bytes(input logic [31:0] crc_in,
                                            input logic [31:0] data,
                                            input logic [2:0]  n_bytes);
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(n_bytes)) begin
        c = c ^ {24'h000000, data[8*b +: 8]};
        for (int i = 0; i < 8; i++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  function automatic logic [2:0] keep_count(input logic [3:0] keep);
    logic [2:0] n;
    case (keep)
      4'b0001: n = 3'd1;
      4'b0011: n = 3'd2;
      4'b0111: n = 3'd3;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [2:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {14'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] tail_data_q, tail_data_d;
  logic [3:0]  tail_keep_q, tail_keep_d;
  logic [31:0] m_data_q, m_data_d;
  logic [3:0]  m_keep_q, m_keep_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;

  logic        slot_free_s;
  logic        s_ready_s;
  logic [2:0]  k_s;
  logic [31:0] data_masked_s;
  logic [16:0] total_s;
  logic [16:0] cnt_plus4_s;
  logic [31:0] crc_full_s;
  logic [31:0] crc_pad_s;
  logic [31:0] crc_part_s;
  logic [31:0] fcs_part_s;
  logic [31:0] crc_zero_s;

  // Handshake qualifiers and the candidate CRC values for this cycle.
  always_comb begin
    slot_free_s   = !m_valid_q || m_ready;
    s_ready_s     = (state_q == ST_DATA) && slot_free_s && !rst;
    k_s           = keep_count(s_keep);
    data_masked_s = s_data & {{8{s_keep[3]}}, {8{s_keep[2]}}, {8{s_keep[1]}}, {8{s_keep[0]}}};
    total_s       = {1'b0, byte_cnt_q} + {14'd0, k_s};
    cnt_plus4_s   = {1'b0, byte_cnt_q} + 17'd4;
    crc_full_s    = crc_bytes(crc_q, s_data, 3'd4);
    crc_pad_s     = crc_bytes(crc_q, data_masked_s, 3'd4);
    crc_part_s    = crc_bytes(crc_q, s_data, k_s);
    fcs_part_s    = ~crc_part_s;
    crc_zero_s    = crc_bytes(crc_q, 32'h00000000, 3'd4);
  end

  // Frame FSM and next value of the output register slot.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    byte_cnt_d  = byte_cnt_q;
    tail_data_d = tail_data_q;
    tail_keep_d = tail_keep_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_last_d    = m_last_q;
    m_valid_d   = slot_free_s ? 1'b0 : m_valid_q;

    case (state_q)
      ST_DATA: begin
        if (s_valid && s_ready_s) begin
          m_valid_d = 1'b1;
          m_keep_d  = 4'b1111;
          m_last_d  = 1'b0;
          if (!s_last) begin
            m_data_d   = s_data;
            crc_d      = crc_full_s;
            byte_cnt_d = sat_add(byte_cnt_q, 3'd4);
          end else if (PAD_EN && (total_s < MIN_LEN)) begin
            // Short frame: unused lanes become the first pad bytes.
            m_data_d   = data_masked_s;
            crc_d      = crc_pad_s;
            byte_cnt_d = sat_add(byte_cnt_q, 3'd4);
            state_d    = (cnt_plus4_s >= MIN_LEN) ? ST_FCS_FULL : ST_PAD;
          end else if (k_s == 3'd4) begin
            m_data_d   = s_data;
            crc_d      = crc_full_s;
            byte_cnt_d = sat_add(byte_cnt_q, 3'd4);
            state_d    = ST_FCS_FULL;
          end else begin
            // Partial last beat: FCS starts in the first free lane, rest goes to the tail beat.
            crc_d      = crc_part_s;
            byte_cnt_d = sat_add(byte_cnt_q, k_s);
            state_d    = ST_FCS_TAIL;
            case (k_s)
              3'd1: begin
                m_data_d    = {fcs_part_s[23:0], s_data[7:0]};
                tail_data_d = {24'h000000, fcs_part_s[31:24]};
                tail_keep_d = 4'b0001;
              end
              3'd2: begin
                m_data_d    = {fcs_part_s[15:0], s_data[15:0]};
                tail_data_d = {16'h0000, fcs_part_s[31:16]};
                tail_keep_d = 4'b0011;
              end
              3'd3: begin
                m_data_d    = {fcs_part_s[7:0], s_data[23:0]};
                tail_data_d = {8'h00, fcs_part_s[31:8]};
                tail_keep_d = 4'b0111;
              end
              default: begin
                m_data_d    = s_data;
                tail_data_d = 32'h00000000;
                tail_keep_d = 4'b0000;
              end
            endcase
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_PAD: begin
        if (slot_free_s) begin
          m_valid_d  = 1'b1;
          m_data_d   = 32'h00000000;
          m_keep_d   = 4'b1111;
          m_last_d   = 1'b0;
          crc_d      = crc_zero_s;
          byte_cnt_d = sat_add(byte_cnt_q, 3'd4);
          state_d    = (cnt_plus4_s >= MIN_LEN) ? ST_FCS_FULL : ST_PAD;
        end else begin
          state_d = ST_PAD;
        end
      end

      ST_FCS_FULL: begin
        if (slot_free_s) begin
          m_valid_d  = 1'b1;
          m_data_d   = ~crc_q;
          m_keep_d   = 4'b1111;
          m_last_d   = 1'b1;
          crc_d      = CRC_INIT;
          byte_cnt_d = 16'h0000;
          state_d    = ST_DATA;
        end else begin
          state_d = ST_FCS_FULL;
        end
      end

      ST_FCS_TAIL: begin
        if (slot_free_s) begin
          m_valid_d  = 1'b1;
          m_data_d   = tail_data_q;
          m_keep_d   = tail_keep_q;
          m_last_d   = 1'b1;
          crc_d      = CRC_INIT;
          byte_cnt_d = 16'h0000;
          state_d    = ST_DATA;
        end else begin
          state_d = ST_FCS_TAIL;
        end
      end

      default: begin
        state_d = ST_DATA;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DATA;
      crc_q       <= CRC_INIT;
      byte_cnt_q  <= 16'h0000;
      tail_data_q <= 32'h00000000;
      tail_keep_q <= 4'b0000;
      m_data_q    <= 32'h00000000;
      m_keep_q    <= 4'b0000;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      byte_cnt_q  <= byte_cnt_d;
      tail_data_q <= tail_data_d;
      tail_keep_q <= tail_keep_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
    end
  end

  assign s_ready = s_ready_s;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_eth_tx_fcs_insert.sv
// Scoreboard bench: a padding and a non-padding instance, fed from a byte-level
// frame model; a monitor checks beats, stall stability and the CRC residue.
module tb_eth_tx_fcs_insert;

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam int          MIN_LEN = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data  [2];
  logic [3:0]  s_keep  [2];
  logic        s_valid [2];
  logic        s_last  [2];
  logic        s_ready [2];
  logic [31:0] m_data  [2];
  logic [3:0]  m_keep  [2];
  logic        m_valid [2];
  logic        m_last  [2];
  logic        m_ready [2];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [36:0] exp0 [$];
  logic [36:0] exp1 [$];
  byte unsigned res0 [$];
  byte unsigned res1 [$];
  logic        ignore  [2];
  logic        stall_v [2];
  logic [36:0] held    [2];
  logic        bp_en = 1'b0;

  eth_tx_fcs_insert #(.ENABLE_PAD(1), .MIN_FRAME_LEN(60)) dut_pad (
    .clk(clk), .rst(rst),
    .s_data(s_data[0]), .s_keep(s_keep[0]), .s_valid(s_valid[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
    .m_data(m_data[0]), .m_keep(m_keep[0]), .m_valid(m_valid[0]), .m_last(m_last[0]), .m_ready(m_ready[0])
  );

  eth_tx_fcs_insert #(.ENABLE_PAD(0), .MIN_FRAME_LEN(60)) dut_nopad (
    .clk(clk), .rst(rst),
    .s_data(s_data[1]), .s_keep(s_keep[1]), .s_valid(s_valid[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
    .m_data(m_data[1]), .m_keep(m_keep[1]), .m_valid(m_valid[1]), .m_last(m_last[1]), .m_ready(m_ready[1])
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] crc_ref(input byte unsigned bytes[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (bytes[i]) begin
      c = c ^ {24'h000000, bytes[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void push_exp(input int u, input logic [36:0] beat);
    if (u == 0) exp0.push_back(beat);
    else        exp1.push_back(beat);
  endfunction

  // Output bytes = data, zero pad (if enabled) to MIN_LEN, then ~CRC LSB first.
  task automatic model_frame(input int u, input byte unsigned fr[$], input bit pad);
    byte unsigned ob[$];
    logic [31:0]  fcs;
    logic [31:0]  d;
    logic [3:0]   k;
    int           n;
    ob = fr;
    if (pad) while (ob.size() < MIN_LEN) ob.push_back(8'h00);
    fcs = ~crc_ref(ob);
    for (int i = 0; i < 4; i++) ob.push_back(fcs[8*i +: 8]);
    n = int'(ob.size());
    for (int i = 0; i < n; i += 4) begin
      d = 32'h0;
      k = 4'h0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < n) begin
          d[8*j +: 8] = ob[i+j];
          k[j] = 1'b1;
        end
      end
      push_exp(u, {(i + 4 >= n), k, d});
    end
  endtask

  task automatic drive_frame(input int u, input byte unsigned fr[$], input int max_beats);
    int n;
    int nb;
    n  = int'(fr.size());
    nb = (n + 3) / 4;
    if (max_beats < nb) nb = max_beats;
    for (int b = 0; b < nb; b++) begin
      logic [31:0] d;
      logic [3:0]  k;
      int          waited;
      bit          acc;
      d = 32'h0;
      k = 4'h0;
      for (int j = 0; j < 4; j++) begin
        if (4*b + j < n) begin
          d[8*j +: 8] = fr[4*b + j];
          k[j] = 1'b1;
        end
      end
      while ($urandom_range(0, 3) == 0) begin
        s_valid[u] = 1'b0;
        @(posedge clk); #1;
      end
      s_data[u]  = d;
      s_keep[u]  = k;
      s_last[u]  = (4*b + 4 >= n);
      s_valid[u] = 1'b1;
      acc    = 1'b0;
      waited = 0;
      while (!acc && waited < 4000) begin
        @(negedge clk);
        acc = s_ready[u];
        @(posedge clk); #1;
        waited++;
      end
      if (!acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: unit %0d beat %0d accepted=0, required 1", u, b);
      end
      s_valid[u] = 1'b0;
    end
  endtask

  task automatic send_frame(input int u, input byte unsigned fr[$]);
    model_frame(u, fr, (u == 0));
    drive_frame(u, fr, 1 << 30);
  endtask

  function automatic void rand_frame(input int len, output byte unsigned fr[$]);
    fr = {};
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom_range(0, 255)));
  endfunction

  task automatic drain();
    int t;
    t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20000) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: pending %0d/%0d beats, required 0", exp0.size(), exp1.size());
    end
  endtask

  // Downstream ready: always on, or 50% random backpressure.
  initial begin
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) m_ready[u] = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: stall stability, scoreboard pop/compare, per-frame residue.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [36:0] e;
      logic [31:0] mask;
      byte unsigned rb[$];
      if (rst) begin
        stall_v[u] = 1'b0;
        if (u == 0) res0 = {};
        else        res1 = {};
      end else begin
        if (stall_v[u]) check("stall_hold", 64'({m_last[u], m_keep[u], m_data[u]}), 64'(held[u]));
        stall_v[u] = m_valid[u] && !m_ready[u];
        held[u]    = {m_last[u], m_keep[u], m_data[u]};
        if (m_valid[u] && m_ready[u] && !ignore[u]) begin
          if ((u == 0 && exp0.size() == 0) || (u == 1 && exp1.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: unit %0d got %0h, required no beat", u, m_data[u]);
          end else begin
            e    = (u == 0) ? exp0.pop_front() : exp1.pop_front();
            mask = {{8{e[35]}}, {8{e[34]}}, {8{e[33]}}, {8{e[32]}}};
            check("beat", 64'({m_last[u], m_keep[u], m_data[u] & mask}), 64'({e[36], e[35:32], e[31:0] & mask}));
            rb = (u == 0) ? res0 : res1;
            for (int j = 0; j < 4; j++) if (m_keep[u][j]) rb.push_back(m_data[u][8*j +: 8]);
            if (m_last[u]) begin
              check("residue", 64'(crc_ref(rb)), 64'(RESIDUE));
              rb = {};
            end
            if (u == 0) res0 = rb;
            else        res1 = rb;
          end
        end
      end
    end
  end

  initial begin
    byte unsigned fr[$];
    for (int u = 0; u < 2; u++) begin
      s_data[u]  = 32'h0;
      s_keep[u]  = 4'h0;
      s_valid[u] = 1'b0;
      s_last[u]  = 1'b0;
      ignore[u]  = 1'b0;
      stall_v[u] = 1'b0;
      held[u]    = 37'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_m_valid", 64'(m_valid[u]), 64'(0));
      check("rst_m_last",  64'(m_last[u]),  64'(0));
      check("rst_m_keep",  64'(m_keep[u]),  64'(0));
      check("rst_m_data",  64'(m_data[u]),  64'(0));
      check("rst_s_ready", 64'(s_ready[u]), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // "123456789" without padding: FCS 0xCBF43926 split across the last two beats.
    fr = {};
    for (int i = 0; i < 9; i++) fr.push_back(8'(49 + i));
    exp1.push_back({1'b0, 4'b1111, 32'h34333231});
    exp1.push_back({1'b0, 4'b1111, 32'h38373635});
    exp1.push_back({1'b0, 4'b1111, 32'hF4392639});
    exp1.push_back({1'b1, 4'b0001, 32'h000000CB});
    drive_frame(1, fr, 1 << 30);
    drain();

    // Single byte 0xAA padded to 64 bytes on the wire.
    fr = {};
    fr.push_back(8'hAA);
    exp0.push_back({1'b0, 4'b1111, 32'h000000AA});
    for (int i = 1; i < 15; i++) exp0.push_back({1'b0, 4'b1111, 32'h00000000});
    begin
      byte unsigned padded[$];
      padded = fr;
      while (padded.size() < 60) padded.push_back(8'h00);
      exp0.push_back({1'b1, 4'b1111, ~crc_ref(padded)});
    end
    drive_frame(0, fr, 1 << 30);
    drain();

    // Long random frames, all four residual lengths, no backpressure.
    for (int i = 0; i < 8; i++) begin
      rand_frame(4 * $urandom_range(15, 378) + (i % 4), fr);
      send_frame(0, fr);
    end
    for (int i = 0; i < 6; i++) begin
      rand_frame($urandom_range(1, 59), fr);
      send_frame(0, fr);
    end
    drain();

    // Back-to-back frames under 50% backpressure on both instances.
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) rand_frame($urandom_range(1, 64), fr);
      else            rand_frame($urandom_range(60, 400), fr);
      send_frame(0, fr);
    end
    for (int i = 0; i < 8; i++) begin
      rand_frame($urandom_range(1, 80), fr);
      send_frame(1, fr);
    end
    bp_en = 1'b0;
    drain();

    // Reset in the middle of a 100-byte frame, then a clean 64-byte frame.
    ignore[0] = 1'b1;
    rand_frame(100, fr);
    drive_frame(0, fr, 10);
    rst = 1'b1;
    @(negedge clk);
    check("s_ready_in_rst", 64'(s_ready[0]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("m_valid_after_rst", 64'(m_valid[0]), 64'(0));
    ignore[0] = 1'b0;
    @(posedge clk); #1;
    rand_frame(64, fr);
    send_frame(0, fr);
    drain();

    repeat (4) @(posedge clk);
    check("exp0_empty", 64'(exp0.size()), 64'(0));
    check("exp1_empty", 64'(exp1.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
